// File: rtl/blob_frame_sequencer.sv
// Runs one blob-count job per request: arms the counter, streams one binarised frame, waits for the count, holds the result.
// Registered outputs, 1-cycle pixel latency; pixel stream gaps or a hung/stuck counter abort the job and pulse the counter reset.
module blob_frame_sequencer #(
    parameter int IMG_COL = 800,
    parameter int IMG_ROW = 600,
    parameter int PIX_W   = 12,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [PIX_W-1:0] i_threshold,
    input  logic             i_invert,
    output logic             o_rd_start,
    input  logic             i_pix_valid,
    input  logic [PIX_W-1:0] i_pix_data,
    output logic             o_blob_rst_n,
    output logic             o_blob_valid,
    output logic             o_blob_seq,
    input  logic             i_blob_done,
    input  logic [CNT_W-1:0] i_blob_count,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_valid,
    output logic             o_busy,
    output logic [1:0]       o_error
);

    localparam int          NPIX     = IMG_COL * IMG_ROW;
    localparam logic [19:0] LAST_PIX = 20'(NPIX - 1);
    localparam int          TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] LAST_TO = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_GAP     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_STREAM,
        S_WAIT_DONE,
        S_RELEASE,
        S_ABORT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        err_code;
    logic [19:0]       pix_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              abort_cnt;
    logic [PIX_W-1:0]  thr_q;
    logic              inv_q;
    logic              pix_bin;
    logic              accept_start;
    logic              enter_abort;
    logic              capture;

    assign pix_bin      = (i_pix_data >= thr_q) ^ inv_q;
    assign accept_start = (state == S_IDLE) && i_start;
    assign enter_abort  = (next_state == S_ABORT) && (state != S_ABORT);
    assign capture      = (state == S_WAIT_DONE) && (next_state == S_RELEASE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        err_code   = ERR_NONE;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    next_state = S_ARM;
                end
            end
            S_ARM: begin
                next_state = S_STREAM;
            end
            S_STREAM: begin
                if (!i_pix_valid) begin
                    next_state = S_ABORT;
                    err_code   = ERR_GAP;
                end else if (pix_cnt == LAST_PIX) begin
                    next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // done takes priority over a timeout expiring in the same cycle
                if (i_blob_done) begin
                    next_state = S_RELEASE;
                end else if (to_cnt == LAST_TO) begin
                    next_state = S_ABORT;
                    err_code   = ERR_TIMEOUT;
                end
            end
            S_RELEASE: begin
                if (!i_blob_done) begin
                    next_state = S_IDLE;
                end else if (to_cnt == LAST_TO) begin
                    next_state = S_ABORT;
                    err_code   = ERR_TIMEOUT;
                end
            end
            S_ABORT: begin
                if (abort_cnt) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Job bookkeeping: pixel counter, per-state timeout, abort hold, latched compare settings.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix_cnt   <= '0;
            to_cnt    <= '0;
            abort_cnt <= 1'b0;
            thr_q     <= '0;
            inv_q     <= 1'b0;
        end else begin
            if (state == S_ARM) begin
                pix_cnt <= '0;
            end else if ((state == S_STREAM) && i_pix_valid) begin
                pix_cnt <= pix_cnt + 20'd1;
            end

            if ((next_state == state) &&
                ((state == S_WAIT_DONE) || (state == S_RELEASE))) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            abort_cnt <= (state == S_ABORT) ? ~abort_cnt : 1'b0;

            if (accept_start) begin
                thr_q <= i_threshold;
                inv_q <= i_invert;
            end
        end
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_start    <= 1'b0;
            o_blob_rst_n  <= 1'b0;
            o_blob_valid  <= 1'b0;
            o_blob_seq    <= 1'b0;
            o_count       <= '0;
            o_count_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_error       <= ERR_NONE;
        end else begin
            o_rd_start    <= accept_start;
            o_blob_rst_n  <= (next_state != S_ABORT);
            o_blob_valid  <= (next_state == S_STREAM) || (next_state == S_WAIT_DONE);
            o_blob_seq    <= (state == S_STREAM) && i_pix_valid && pix_bin;
            o_count_valid <= capture;
            o_busy        <= (next_state != S_IDLE);
            if (capture) begin
                o_count <= i_blob_count;
            end
            if (accept_start) begin
                o_error <= ERR_NONE;
            end else if (enter_abort) begin
                o_error <= err_code;
            end
        end
    end

endmodule

// File: doc/blob_frame_sequencer.md
Name: blob_frame_sequencer

Overview:
Controller that runs one blob-count job per request. It arms the blob-counting pipeline, streams one full frame of thresholded binary pixels from the frame-buffer read port into it, waits for the count, then captures and holds the result. It sits between the SDRAM frame-buffer reader and the blob counter, and reports to the display/HEX logic. It also owns the blob counter's reset, so it can abort and recover from a broken stream or a hung counter.

Parameters:
IMG_COL, 800, pixels per row
IMG_ROW, 600, rows per frame
PIX_W, 12, grayscale pixel width
CNT_W, 8, blob count width
TIMEOUT, 4096, max cycles in WAIT_DONE before abort

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  job request pulse; ignored unless IDLE
i_threshold  in  PIX_W  binarization threshold, sampled in IDLE on i_start
i_invert  in  1  invert binary polarity, sampled with i_threshold
o_rd_start  out  1  one-cycle pulse telling frame reader to begin streaming
i_pix_valid  in  1  pixel valid from frame reader; must be high every STREAM cycle
i_pix_data  in  PIX_W  grayscale pixel
o_blob_rst_n  out  1  active-low reset to blob counter
o_blob_valid  out  1  run/hold level to blob counter
o_blob_seq  out  1  binary pixel to blob counter
i_blob_done  in  1  blob counter result valid (level)
i_blob_count  in  CNT_W  blob counter result
o_count  out  CNT_W  last captured count
o_count_valid  out  1  one-cycle pulse when o_count updates
o_busy  out  1  high in any state except IDLE
o_error  out  2  0 none, 1 stream gap, 2 timeout; sticky until next accepted i_start

Behaviour:
- All outputs registered. Reset values:
  - o_blob_rst_n=0 while i_rst is high; it goes to 1 the cycle after reset releases.
  - All other outputs 0. State IDLE.
- States: IDLE, ARM, STREAM, WAIT_DONE, RELEASE, ABORT.
- IDLE:
  - On i_start: latch threshold/invert, clear o_error, go to ARM.
- ARM (exactly 1 cycle, call it cycle A):
  - o_rd_start=1. Pixel counter cleared. Go to STREAM.
- o_blob_valid timing: rises at A+1 and stays high through STREAM and WAIT_DONE.
- STREAM:
  - Pixel k (k=0..N-1, N=IMG_COL*IMG_ROW) is expected with i_pix_valid at cycle A+1+k.
  - o_blob_seq at A+2+k = (i_pix_data >= threshold) XOR invert. Registered, latency 1.
  - Pixel counter is 20 bits and counts accepted pixels.
  - After pixel N-1 is accepted, go to WAIT_DONE. From then on o_blob_seq=0.
  - i_pix_valid low in any STREAM cycle: go to ABORT with o_error=1.
  - Extra i_pix_valid beats outside STREAM are ignored.
- WAIT_DONE:
  - Timeout counter starts at 0 on entry.
  - i_blob_done high: register o_count=i_blob_count, pulse o_count_valid for 1 cycle, go to RELEASE.
  - Timeout counter reaches TIMEOUT-1 without done: go to ABORT with o_error=2.
  - Done and timeout in the same cycle: done wins.
- RELEASE:
  - o_blob_valid=0. Stay until i_blob_done is low, then go to IDLE.
  - Stuck-high done is also bounded by TIMEOUT: go to ABORT with o_error=2.
- ABORT:
  - o_blob_valid=0, o_blob_seq=0, o_blob_rst_n=0 for exactly 2 cycles, then IDLE.
  - o_count unchanged, no o_count_valid pulse.
- Busy requests: i_start in any non-IDLE state is dropped, not queued.
- o_count holds its last good value across jobs and aborts. It is cleared only by i_rst.
- Reset mid-operation: immediate return to IDLE with reset values. o_blob_rst_n stays low for the reset duration, so the blob counter is cleared too.

Test Plan:
- Normal job (IMG_COL=8, IMG_ROW=4, threshold 0x800, blob model answering done=1/count=3 fifteen cycles after stream end):
  - i_start, then 32 contiguous pixels.
  - Expect o_rd_start at A, o_blob_valid from A+1, 32 seq bits matching the threshold compare from A+2.
  - Expect o_count=3 with a 1-cycle o_count_valid, then RELEASE, then IDLE once done drops.
- Threshold edges: pixel=0x7FF gives seq 0 and pixel=0x800 gives seq 1 with invert=0; both flip with invert=1.
- Stream gap: drop i_pix_valid at pixel 17.
  - Expect o_error=1, o_blob_rst_n low exactly 2 cycles, o_blob_valid=0, o_count keeps its prior value, no o_count_valid.
- Timeout (TIMEOUT=16): model never asserts done.
  - Expect ABORT entry exactly 16 cycles after WAIT_DONE entry, o_error=2, then IDLE; next i_start clears o_error to 0.
- i_start pulsed during STREAM and WAIT_DONE: ignored, with a single o_rd_start per job.
- i_rst asserted mid-STREAM for 3 cycles:
  - Expect all outputs at reset values and o_blob_rst_n low for those cycles, high on the next cycle.
  - A new i_start then completes normally.
